strobe_mem: RTL and testbench
=============================

Name: strobe_mem

Overview:
- Byte-addressed, little-endian word memory with valid/ready request and response channels.
- Supports per-byte write strobes, configurable read latency, a response buffer with backpressure, and an error flag for out-of-range accesses.
- Successor to the single-port read-only instruction/data memory. Serves as the core's load/store and fetch backing store in simulation and FPGA builds.
- Posedge-clocked throughout.

Parameters:
- XLEN, 32, word width in bits; multiple of 8.
- NB_CELLS, 1024, memory size in bytes.
- LATENCY, 1, cycles from request accept to response entering the buffer; legal range 1..4.
- RESP_DEPTH, 2, maximum outstanding requests (in pipeline plus buffered); must be at least LATENCY+1 for one-per-cycle throughput.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  XLEN  byte address; need not be aligned.
- req_wdata  in  XLEN  write data; byte i is bits [8i+7:8i].
- req_be  in  XLEN/8  byte enables for writes; ignored on reads.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  XLEN  read data; 0 for writes and for errors.
- resp_err  out  1  access out of range.

Behaviour:
- **Accept rule:** a request is accepted when req_valid && req_ready on a rising edge. One request per cycle.
- **req_ready:** equals (outstanding < RESP_DEPTH).
  - outstanding = requests in the latency pipeline + buffer occupancy.
  - Driven from registered state only, so there is no combinational path from resp_ready to req_ready.
- **Range check:** an access covers bytes adr .. adr+XLEN/8-1. If adr+XLEN/8-1 >= NB_CELLS, computed without overflow at XLEN+1 bits:
  - resp_err=1 and resp_data=0;
  - no memory write occurs.
- **Write:** applied at the accept edge.
  - Byte adr+i is updated only if req_be[i]=1.
  - Produces exactly one response: err per the range check, data 0.
- **Read:**
  - Data is sampled at the accept edge as {mem[adr+N-1], ..., mem[adr]}, N = XLEN/8.
  - It then travels a LATENCY-stage valid/data/err shift pipeline.
  - A read accepted the cycle after a write to the same bytes returns the new data.
- **Response buffer:** the pipeline output pushes into a RESP_DEPTH-entry FIFO.
  - The buffer never overflows because of the credit rule, so no push is ever dropped.
  - The head is presented on resp_*; it is popped when resp_valid && resp_ready.
  - Push and pop in the same cycle are both honoured.
  - Empty buffer: resp_valid=0 and resp_data/resp_err hold 0.
- **Latency:** the minimum request-to-resp_valid latency is LATENCY cycles (the accept edge plus LATENCY edges). Responses return strictly in request order.
- **Counters:**
  - Occupancy and pointers wrap modulo RESP_DEPTH.
  - The outstanding counter is $clog2(RESP_DEPTH+1) bits.
  - Accept and pop in the same cycle leave the counter unchanged.
- **Reset (rst_n=0 at an edge):**
  - Pipeline valids, FIFO pointers and the outstanding counter clear to 0.
  - req_ready=0 during reset and 1 on the first cycle after.
  - resp_valid=0, resp_data=0, resp_err=0.
  - Memory contents are not reset; they are preloadable via $readmemh in simulation.
  - Reset mid-operation drops all in-flight responses silently.
  - Requests presented during reset are not accepted.

Decomposition:
- Package mem_pkg holds:
  - the mem_req_t struct (we, adr, wdata, be);
  - the mem_resp_t struct (data, err);
  - the default XLEN constant.
- Sub-module mem_resp_fifo: a generic synchronous FIFO of mem_resp_t, depth RESP_DEPTH, with push/pop/full/empty.
- strobe_mem contains the byte array, the range check, the latency pipeline and the credit counter.

Test Plan:
- Write adr=0x10, wdata=0xDEADBEEF, be=4'b1111, then read 0x10 → write response err=0, data=0; read response data=0xDEADBEEF, err=0.
- Partial write to adr=0x10, wdata=0x000000AA, be=4'b0001, then read → data=0xDEADBEAA.
- Misaligned read adr=0x12 after the above → data=0x????DEAD, with the upper bytes equal to mem[0x15:0x14].
- Out-of-range write then read at adr=1022 (NB_CELLS=1024) → err=1, data=0; mem[1022], mem[1023] unchanged.
- Backpressure, LATENCY=2, RESP_DEPTH=3, resp_ready=0, req_valid held high:
  - exactly 3 requests are accepted, then req_ready=0;
  - releasing resp_ready drains them in order;
  - req_ready reasserts the cycle after the first pop.
- Reset mid-stream: 2 reads in flight, then rst_n=0 for one cycle → resp_valid=0 afterwards, no stale responses, req_ready=1; data written before reset still reads back.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the byte-strobed word memory: request/response records and
// the default word width.
package mem_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef struct packed {
        logic                        we;
        logic [XLEN_DEFAULT-1:0]     adr;
        logic [XLEN_DEFAULT-1:0]     wdata;
        logic [XLEN_DEFAULT/8-1:0]   be;
    } mem_req_t;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0]     data;
        logic                        err;
    } mem_resp_t;

endpackage

// File: rtl/strobe_mem_if.sv
// Request/response channel bundle between a requester (master) and strobe_mem (slave).
interface strobe_mem_if #(
    parameter int XLEN = mem_pkg::XLEN_DEFAULT
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [XLEN-1:0]     req_adr;
    logic [XLEN-1:0]     req_wdata;
    logic [XLEN/8-1:0]   req_be;
    logic                resp_valid;
    logic                resp_ready;
    logic [XLEN-1:0]     resp_data;
    logic                resp_err;

    modport master (
        output req_valid, req_we, req_adr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_adr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/mem_resp_fifo.sv
// Small synchronous FIFO for response records; head reads as all-zero when empty.
module mem_resp_fifo
    import mem_pkg::*;
#(
    parameter type T     = mem_resp_t,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               store [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : store[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/strobe_mem.sv
// Byte-addressed little-endian word memory with per-byte write strobes, a fixed
// read latency pipeline and a credit-limited response buffer.
module strobe_mem
    import mem_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int NB_CELLS   = 1024,
    parameter int LATENCY    = 1,
    parameter int RESP_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    strobe_mem_if.slave  bus
);
    localparam int NB = XLEN / 8;
    localparam int AW = $clog2(NB_CELLS);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            err;
    } resp_t;

    logic [7:0]          mem [NB_CELLS];
    logic                accept;
    logic                pop;
    logic                range_err;
    logic [XLEN:0]       last_adr;
    logic [AW-1:0]       base;
    logic [XLEN-1:0]     rd_word;
    resp_t               stage_in;
    logic [LATENCY-1:0]  pipe_v;
    resp_t               pipe_r [LATENCY];
    resp_t               resp_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       outstanding;

    // Extra top bit keeps the end-of-access address from wrapping near the top of the space.
    assign last_adr  = {1'b0, bus.req_adr} + (XLEN+1)'(NB - 1);
    assign range_err = (last_adr >= (XLEN+1)'(NB_CELLS));
    assign base      = bus.req_adr[AW-1:0];

    assign bus.req_ready = rst_n && (outstanding < CW'(RESP_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.resp_valid && bus.resp_ready;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NB; i++) begin
            rd_word[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    always_comb begin
        stage_in      = '0;
        stage_in.err  = range_err;
        stage_in.data = (bus.req_we || range_err) ? '0 : rd_word;
    end

    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !range_err) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_be[i]) mem[base + AW'(i)] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_r[0] <= stage_in;
        for (int i = 1; i < LATENCY; i++) pipe_r[i] <= pipe_r[i-1];
    end

    // Credits cover both pipeline and buffer, so the buffer can never be full on a push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (accept && !pop) begin
            outstanding <= outstanding + 1'b1;
        end else if (!accept && pop) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    mem_resp_fifo #(
        .T     (resp_t),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_v[LATENCY-1] && !fifo_full),
        .push_data (pipe_r[LATENCY-1]),
        .pop       (pop),
        .head      (resp_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_data  = resp_head.data;
    assign bus.resp_err   = resp_head.err;
endmodule

// File: tb/tb_strobe_mem.sv
// Directed bench for strobe_mem with LATENCY=2, RESP_DEPTH=3, NB_CELLS=1024.
module tb_strobe_mem;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    strobe_mem_if #(.XLEN(32)) bus ();

    strobe_mem #(
        .XLEN       (32),
        .NB_CELLS   (1024),
        .LATENCY    (2),
        .RESP_DEPTH (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
    endtask

    // One request, then wait for its response with resp_ready high.
    // lat counts negedges after the accept edge until resp_valid is seen.
    task automatic xact(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] data, output logic err,
                        output int lat);
        int k;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_adr    = adr;
        bus.req_wdata  = wdata;
        bus.req_be     = be;
        bus.resp_ready = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            idle();
            data = '0;
            err  = 1'b0;
            lat  = -1;
            return;
        end
        @(posedge clk);
        #1 idle();
        lat = 0;
        @(negedge clk);
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) check("resp_timeout", 32'd0, 32'd1);
        data = bus.resp_data;
        err  = bus.resp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          l;
        int          acc;
        logic        rdy;
        logic [31:0] bp_adr [3];
        logic [31:0] bp_exp [3];

        bp_adr[0] = 32'h10;  bp_exp[0] = 32'hDEADBEAA;
        bp_adr[1] = 32'h12;  bp_exp[1] = 32'h1234DEAD;
        bp_adr[2] = 32'd1020; bp_exp[2] = 32'h11223344;

        // Reset, with a request presented that must not be taken
        rst_n = 1'b0;
        idle();
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  {31'd0, bus.req_ready},  32'd0);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_data",  bus.resp_data,           32'd0);
        check("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        #1 check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        check("no_accept_in_rst", {31'd0, bus.resp_valid}, 32'd0);

        // Full write then read
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, d, e, l);
        check("wr_full_data", d, 32'd0);
        check("wr_full_err",  {31'd0, e}, 32'd0);
        xact(1'b0, 32'h10, 32'd0, 4'b0000, d, e, l);
        check("rd_full_data", d, 32'hDEADBEEF);
        check("rd_full_err",  {31'd0, e}, 32'd0);
        check("rd_latency",   l, 32'd2);

        // Partial write of byte 0
        xact(1'b1, 32'h10, 32'h000000AA, 4'b0001, d, e, l);
        xact(1'b0, 32'h10, 32'd0, 4'b0000, d, e, l);
        check("rd_partial", d, 32'hDEADBEAA);

        // Misaligned read across a word boundary
        xact(1'b1, 32'h14, 32'h00001234, 4'b0011, d, e, l);
        xact(1'b0, 32'h12, 32'd0, 4'b0000, d, e, l);
        check("rd_misaligned", d, 32'h1234DEAD);

        // Top-of-memory boundary and out-of-range accesses
        xact(1'b1, 32'd1020, 32'h11223344, 4'b1111, d, e, l);
        check("wr_last_word_err", {31'd0, e}, 32'd0);
        xact(1'b1, 32'd1022, 32'hFFFFFFFF, 4'b1111, d, e, l);
        check("wr_oor_err",  {31'd0, e}, 32'd1);
        check("wr_oor_data", d, 32'd0);
        xact(1'b0, 32'd1022, 32'd0, 4'b0000, d, e, l);
        check("rd_oor_err",  {31'd0, e}, 32'd1);
        check("rd_oor_data", d, 32'd0);
        xact(1'b0, 32'd1021, 32'd0, 4'b0000, d, e, l);
        check("rd_1021_err", {31'd0, e}, 32'd1);
        xact(1'b0, 32'd1020, 32'd0, 4'b0000, d, e, l);
        check("rd_1020_unchanged", d, 32'h11223344);
        check("rd_1020_err", {31'd0, e}, 32'd0);

        // Read accepted the cycle after a write to the same word
        @(negedge clk);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_adr    = 32'h20;
        bus.req_wdata  = 32'hAABBCCDD;
        bus.req_be     = 4'b1111;
        @(posedge clk);
        #1 bus.req_we = 1'b0;
        @(posedge clk);
        #1 idle();
        l = 0;
        @(negedge clk);
        while (!bus.resp_valid && l < 20) begin
            @(negedge clk);
            l++;
        end
        check("b2b_wr_data", bus.resp_data, 32'd0);
        @(negedge clk);
        check("b2b_rd_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("b2b_rd_data",  bus.resp_data, 32'hAABBCCDD);
        @(negedge clk);
        check("b2b_drained", {31'd0, bus.resp_valid}, 32'd0);

        // Backpressure: resp_ready low, req_valid held high
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_adr    = bp_adr[0];
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            rdy = bus.req_ready;
            @(posedge clk);
            if (rdy) acc++;
            #1 if (acc < 3) bus.req_adr = bp_adr[acc];
            @(negedge clk);
        end
        check("bp_accepted", acc, 32'd3);
        check("bp_ready_low", {31'd0, bus.req_ready}, 32'd0);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("bp_valid_%0d", j), {31'd0, bus.resp_valid}, 32'd1);
            check($sformatf("bp_data_%0d", j), bus.resp_data, bp_exp[j]);
            @(posedge clk);
            @(negedge clk);
            if (j == 0) check("bp_ready_reassert", {31'd0, bus.req_ready}, 32'd1);
        end
        check("bp_empty", {31'd0, bus.resp_valid}, 32'd0);

        // Reset with two reads in flight
        xact(1'b1, 32'h40, 32'hCAFEF00D, 4'b1111, d, e, l);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_adr    = 32'h10;
        @(posedge clk);
        #1 bus.req_adr = 32'h12;
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("midrst_ready_low", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        #1 check("midrst_ready_high", {31'd0, bus.req_ready}, 32'd1);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("midrst_no_resp_%0d", j), {31'd0, bus.resp_valid}, 32'd0);
            @(negedge clk);
        end
        xact(1'b0, 32'h40, 32'd0, 4'b0000, d, e, l);
        check("midrst_rd_40", d, 32'hCAFEF00D);
        xact(1'b0, 32'h10, 32'd0, 4'b0000, d, e, l);
        check("midrst_rd_10", d, 32'hDEADBEAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
